// File: rtl/irrigation_zone_ctrl_if.sv
// Bundles the sensor/threshold inputs and the valve/pump drive outputs of irrigation_zone_ctrl.
interface irrigation_zone_ctrl_if #(
   parameter int N_ZONES = 4,
   parameter int M_WIDTH = 7,
   parameter int T_WIDTH = 7
);
   logic                       sec_tick;
   logic [N_ZONES*M_WIDTH-1:0] m_sense;
   logic [N_ZONES*M_WIDTH-1:0] m_thresh;
   logic [T_WIDTH-1:0]         water_time_in;
   logic [N_ZONES-1:0]         zone_en;
   logic                       window_ok;
   logic [N_ZONES-1:0]         valve;
   logic                       pump;
   logic [2:0]                 active_zone;
   logic [1:0]                 state;
   logic                       burst_done;

   modport master (
      output sec_tick, m_sense, m_thresh, water_time_in, zone_en, window_ok,
      input  valve, pump, active_zone, state, burst_done
   );

   modport slave (
      input  sec_tick, m_sense, m_thresh, water_time_in, zone_en, window_ok,
      output valve, pump, active_zone, state, burst_done
   );
endinterface

// File: rtl/irrigation_zone_ctrl.sv
// Round-robin multi-zone irrigation controller: one valve at a time on a shared pump,
// each timed burst followed by an optional soak period.
module irrigation_zone_ctrl #(
   parameter int N_ZONES    = 4,
   parameter int M_WIDTH    = 7,
   parameter int T_WIDTH    = 7,
   parameter int HYST       = 4,
   parameter int SOAK_TICKS = 30
) (
   input logic                   clk,
   input logic                   rst_n,
   irrigation_zone_ctrl_if.slave zc
);
   localparam int ZW = $clog2(N_ZONES);

   typedef enum logic [1:0] {
      ST_STANDBY  = 2'd0,
      ST_WATERING = 2'd1,
      ST_SOAK     = 2'd2
   } state_e;

   localparam logic [T_WIDTH-1:0] CNT_MAX = '1;

   state_e             state_q, state_d;
   logic [ZW-1:0]      zone_q, zone_d;
   logic [ZW-1:0]      rr_q, rr_d;
   logic [T_WIDTH-1:0] water_cnt_q, water_cnt_d;
   logic [T_WIDTH-1:0] soak_cnt_q, soak_cnt_d;
   logic [N_ZONES-1:0] valve_q, valve_d;
   logic               pump_q;
   logic               burst_done_q, burst_done_d;

   logic [N_ZONES-1:0] dry, wet;
   logic               pick_valid;
   logic [ZW-1:0]      pick_zone;
   logic [T_WIDTH-1:0] wt_eff, water_inc, soak_inc;
   logic               stop;

   // The wet comparison is widened by one bit so thresh + HYST cannot wrap.
   always_comb begin
      dry = '0;
      wet = '0;
      for (int i = 0; i < N_ZONES; i++) begin
         dry[i] = zc.zone_en[i] &&
                  (zc.m_sense[i*M_WIDTH +: M_WIDTH] <= zc.m_thresh[i*M_WIDTH +: M_WIDTH]);
         wet[i] = {1'b0, zc.m_sense[i*M_WIDTH +: M_WIDTH]} >
                  ({1'b0, zc.m_thresh[i*M_WIDTH +: M_WIDTH]} + (M_WIDTH+1)'(HYST));
      end
   end

   // Search upward from rr_ptr+1; the first dry zone hit wins.
   always_comb begin
      logic [ZW:0] idx;
      pick_valid = 1'b0;
      pick_zone  = rr_q;
      idx        = '0;
      for (int off = 1; off <= N_ZONES; off++) begin
         idx = {1'b0, rr_q} + (ZW+1)'(off);
         if (idx >= (ZW+1)'(N_ZONES)) idx = idx - (ZW+1)'(N_ZONES);
         if (!pick_valid && dry[idx[ZW-1:0]]) begin
            pick_valid = 1'b1;
            pick_zone  = idx[ZW-1:0];
         end
      end
   end

   assign wt_eff    = (zc.water_time_in == '0) ? T_WIDTH'(1) : zc.water_time_in;
   assign water_inc = (water_cnt_q == CNT_MAX) ? water_cnt_q : water_cnt_q + T_WIDTH'(1);
   assign soak_inc  = (soak_cnt_q == CNT_MAX) ? soak_cnt_q : soak_cnt_q + T_WIDTH'(1);
   assign stop      = (zc.sec_tick && (water_inc >= wt_eff)) || wet[zone_q] ||
                      !zc.zone_en[zone_q] || !zc.window_ok;

   // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      zone_d       = zone_q;
      rr_d         = rr_q;
      water_cnt_d  = water_cnt_q;
      soak_cnt_d   = soak_cnt_q;
      burst_done_d = 1'b0;
      case (state_q)
         ST_STANDBY: begin
            if (zc.window_ok && pick_valid) begin
               state_d     = ST_WATERING;
               zone_d      = pick_zone;
               water_cnt_d = '0;
            end
         end
         ST_WATERING: begin
            if (stop) begin
               rr_d         = zone_q;
               burst_done_d = 1'b1;
               water_cnt_d  = '0;
               soak_cnt_d   = '0;
               state_d      = (SOAK_TICKS == 0) ? ST_STANDBY : ST_SOAK;
            end else if (zc.sec_tick) begin
               water_cnt_d = water_inc;
            end
         end
         ST_SOAK: begin
            if (zc.sec_tick) begin
               if (int'(soak_inc) >= SOAK_TICKS) begin
                  state_d    = ST_STANDBY;
                  soak_cnt_d = '0;
               end else begin
                  soak_cnt_d = soak_inc;
               end
            end
         end
         default: state_d = ST_STANDBY;
      endcase
      valve_d = '0;
      if (state_d == ST_WATERING) valve_d[zone_d] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_STANDBY;
         zone_q       <= '0;
         rr_q         <= ZW'(N_ZONES-1);
         water_cnt_q  <= '0;
         soak_cnt_q   <= '0;
         valve_q      <= '0;
         pump_q       <= 1'b0;
         burst_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         zone_q       <= zone_d;
         rr_q         <= rr_d;
         water_cnt_q  <= water_cnt_d;
         soak_cnt_q   <= soak_cnt_d;
         valve_q      <= valve_d;
         pump_q       <= |valve_d;
         burst_done_q <= burst_done_d;
      end
   end

   assign zc.valve       = valve_q;
   assign zc.pump        = pump_q;
   assign zc.active_zone = 3'(zone_q);
   assign zc.state       = state_q;
   assign zc.burst_done  = burst_done_q;
endmodule
